edge_search_gen: RTL and testbench
==================================

Name: edge_search_gen

Overview:
- Parametrised, run-length-qualified rectangular pixel scanner.
- Walks a window in one of four directions and requests one binary pixel at a time from the pixel cache over a req/ready handshake.
- Reports the first run of `min_run` consecutive target-polarity pixels along the scan line.
- Adds over the first-generation searcher: configurable coordinate width, target polarity (dark or light edge), noise-rejecting run length, scan-line stride, abort, and empty/inverted-window handling.

Parameters:
- COORD_W, 10, width of every x/y coordinate.
- RUN_W, 4, width of min_run.
- STRIDE_W, 4, width of stride.

Ports:
- clk  in  1  system clock.
- reset_n  in  1  asynchronous reset, active-low.
- start  in  1  begin search; sampled only in IDLE or DONE.
- abort  in  1  terminate current search.
- search_x0, search_y0, search_x1, search_y1  in  COORD_W each  inclusive window corners.
- direction  in  2  0=UP, 1=DOWN, 2=LEFT, 3=RIGHT.
- polarity  in  1  target pixel value.
- min_run  in  RUN_W  consecutive target pixels required; 0 is treated as 1.
- stride  in  STRIDE_W  major-axis step between scan lines; 0 is treated as 1.
- busy  out  1  high from LOAD through EVAL.
- done  out  1  search complete; level signal.
- found  out  1  valid with done.
- found_x, found_y  out  COORD_W each  first pixel of the qualifying run.
- pix_x, pix_y  out  COORD_W each  requested pixel.
- req  out  1  pixel request.
- pix  in  1  pixel value; valid when ready=1.
- ready  in  1  cache response.

Behaviour:
- Reset (reset_n=0, asynchronous): state IDLE; busy, done, found, req = 0; found_x, found_y, pix_x, pix_y = 0; run counter = 0.
- Window and mode inputs are latched in LOAD. Changes to them after LOAD are ignored.
- States:
  - IDLE: on start, go to LOAD.
  - LOAD: latch inputs and set the start corner. If x0>x1 or y0>y1, go to DONE with found=0 and issue no request. Otherwise go to REQ.
  - REQ: drive req=1 with pix_x/pix_y held stable. Stay until ready=1 at a clock edge, capture pix, go to EVAL.
  - EVAL: update the run counter and step the coordinates. Go to DONE if the run qualifies or the step leaves the window; otherwise go to REQ.
  - DONE: hold results; start goes to LOAD and clears done/found.
- Handshake:
  - req drops in the cycle after ready is sampled.
  - ready while req=0 is ignored.
  - Start to first req: 2 cycles.
  - Minimum pixel period: 2 cycles (REQ, EVAL).
- Scan order (the minor axis runs along the scan line; the major axis advances by stride at each line wrap):
  - RIGHT: start at (x0,y0); x+1; at x1 wrap x to x0 and add stride to y.
  - LEFT: start at (x1,y0); x-1; at x0 wrap x to x1 and add stride to y.
  - DOWN: start at (x0,y0); y+1; at y1 wrap y to y0 and add stride to x.
  - UP: start at (x0,y1); y-1; at y0 wrap y to y1 and add stride to x.
- Arithmetic: internal counters are COORD_W+1 bits. A major-axis advance beyond x1 or y1, including past 2^COORD_W-1, means not found. The run counter saturates at 2^RUN_W-1.
- Run logic:
  - A target pixel increments the run; a pixel of the opposite value clears it.
  - When the run goes from 0 to 1, the pixel coordinates are stored as the run start.
  - A line wrap clears the run, so runs never span scan lines.
  - When run == max(min_run,1): found=1, found_x/found_y = run start, done=1 the next cycle.
- Not-found completion: window exhausted gives done=1, found=0, found_x/found_y = 0.
- Abort:
  - In LOAD/REQ/EVAL: go to DONE the next cycle with found=0. req drops in the same transition; a ready arriving then is ignored.
  - In IDLE/DONE: no effect.
  - abort and start in the same cycle: abort wins in LOAD/REQ/EVAL; start wins in IDLE/DONE.

Optional Feature:
- Macro EDGE_SEARCH_GEN_PIXCOUNT_EN.
- When defined: adds output pix_count [2*COORD_W] = number of pixels evaluated in the current search. It is cleared in LOAD, incremented in each EVAL, and held in DONE.
- When undefined: the port and counter are absent; all other behaviour is identical.

Decomposition:
- Package edge_search_pkg:
  - dir_t enum (UP=2'd0, DOWN=2'd1, LEFT=2'd2, RIGHT=2'd3).
  - state_t enum (IDLE, LOAD, REQ, EVAL, DONE).
  - default COORD_W constant.
- Sub-module scan_walker: holds the coordinate counters, corner init, stepping, wrap, stride and out-of-window flag. The top level keeps the FSM, handshake, run counter and results.

Test Plan:
- Window (0,0)-(9,9), RIGHT, polarity 1, min_run 1, only (5,5)=1, ready 1 cycle after each req -> found=1 at (5,5); 56 pixels requested (pix_count=56).
- Same window, RIGHT, min_run 3, ones at (3,2),(4,2),(8,1),(9,1),(0,2),(7,4),(8,4),(9,4) -> found at (7,4). The (9,1)->(0,2) wrap does not qualify.
- Same window, DOWN, stride 2, only (1,5)=1 -> done, found=0; 50 requests; columns 0,2,4,6,8 only.
- UP and LEFT with only (0,0)=1 -> UP found at (0,0) after 10 requests; LEFT found at (0,0) after 10 requests.
- Window x0=5, x1=3 -> done=1, found=0, req never asserted. Separately, polarity 0 on an all-ones image -> found=0 after 100 requests.
- Abort while req=1 with ready withheld -> next cycle done=1, found=0, req=0. Then reset_n low mid-search -> all outputs 0 asynchronously; the next start runs normally.

Source files
------------

// File: rtl/edge_search_pkg.sv
// Shared types for the run-length-qualified edge searcher: scan directions,
// controller states and the default coordinate width.
package edge_search_pkg;

  localparam int unsigned COORD_W_DEF = 10;

  typedef enum logic [1:0] {
    UP    = 2'd0,
    DOWN  = 2'd1,
    LEFT  = 2'd2,
    RIGHT = 2'd3
  } dir_t;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    LOAD = 3'd1,
    REQ  = 3'd2,
    EVAL = 3'd3,
    DONE = 3'd4
  } state_t;

endpackage

// File: rtl/scan_walker.sv
// Coordinate walker for edge_search_gen: latches the window, places the start
// corner, and steps along scan lines with stride-advanced line wraps.
module scan_walker
  import edge_search_pkg::*;
#(
  parameter int unsigned COORD_W  = COORD_W_DEF,
  parameter int unsigned STRIDE_W = 4
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                load,
  input  logic                step,
  input  logic [COORD_W-1:0]  x0,
  input  logic [COORD_W-1:0]  y0,
  input  logic [COORD_W-1:0]  x1,
  input  logic [COORD_W-1:0]  y1,
  input  logic [1:0]          direction,
  input  logic [STRIDE_W-1:0] stride,
  output logic [COORD_W-1:0]  cur_x,
  output logic [COORD_W-1:0]  cur_y,
  output logic                line_wrap,
  output logic                out_of_window
);

  // One spare bit so a major-axis advance past the top of the range is visible.
  localparam int unsigned CW = COORD_W + 1;

  logic [CW-1:0] x_q, y_q;
  logic [CW-1:0] x0_q, y0_q, x1_q, y1_q;
  logic [CW-1:0] stride_q;
  dir_t          dir_q;

  logic [CW-1:0] nx, ny, cx, cy, adv_x, adv_y;

  assign cur_x = x_q[COORD_W-1:0];
  assign cur_y = y_q[COORD_W-1:0];

  always_comb begin
    cx = {1'b0, x0};
    cy = {1'b0, y0};
    if (dir_t'(direction) == LEFT) cx = {1'b0, x1};
    if (dir_t'(direction) == UP)   cy = {1'b0, y1};
  end

  always_comb begin
    adv_x         = x_q + stride_q;
    adv_y         = y_q + stride_q;
    nx            = x_q;
    ny            = y_q;
    line_wrap     = 1'b0;
    out_of_window = 1'b0;
    unique case (dir_q)
      RIGHT: begin
        if (x_q == x1_q) begin
          line_wrap     = 1'b1;
          out_of_window = adv_y > y1_q;
          nx            = x0_q;
          ny            = adv_y;
        end else begin
          nx = x_q + CW'(1);
        end
      end
      LEFT: begin
        if (x_q == x0_q) begin
          line_wrap     = 1'b1;
          out_of_window = adv_y > y1_q;
          nx            = x1_q;
          ny            = adv_y;
        end else begin
          nx = x_q - CW'(1);
        end
      end
      DOWN: begin
        if (y_q == y1_q) begin
          line_wrap     = 1'b1;
          out_of_window = adv_x > x1_q;
          ny            = y0_q;
          nx            = adv_x;
        end else begin
          ny = y_q + CW'(1);
        end
      end
      UP: begin
        if (y_q == y0_q) begin
          line_wrap     = 1'b1;
          out_of_window = adv_x > x1_q;
          ny            = y1_q;
          nx            = adv_x;
        end else begin
          ny = y_q - CW'(1);
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      x_q      <= '0;
      y_q      <= '0;
      x0_q     <= '0;
      y0_q     <= '0;
      x1_q     <= '0;
      y1_q     <= '0;
      stride_q <= CW'(1);
      dir_q    <= UP;
    end else if (load) begin
      x_q      <= cx;
      y_q      <= cy;
      x0_q     <= {1'b0, x0};
      y0_q     <= {1'b0, y0};
      x1_q     <= {1'b0, x1};
      y1_q     <= {1'b0, y1};
      stride_q <= (stride == '0) ? CW'(1) : CW'(stride);
      dir_q    <= dir_t'(direction);
    end else if (step) begin
      x_q <= nx;
      y_q <= ny;
    end
  end

endmodule

// File: rtl/edge_search_gen.sv
// Run-length-qualified window scanner: fetches one pixel per req/ready
// handshake and reports the first run of min_run target pixels on a scan line.
// Define EDGE_SEARCH_GEN_PIXCOUNT_EN to add the pix_count output.
module edge_search_gen
  import edge_search_pkg::*;
#(
  parameter int unsigned COORD_W  = COORD_W_DEF,
  parameter int unsigned RUN_W    = 4,
  parameter int unsigned STRIDE_W = 4
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  start,
  input  logic                  abort,
  input  logic [COORD_W-1:0]    search_x0,
  input  logic [COORD_W-1:0]    search_y0,
  input  logic [COORD_W-1:0]    search_x1,
  input  logic [COORD_W-1:0]    search_y1,
  input  logic [1:0]            direction,
  input  logic                  polarity,
  input  logic [RUN_W-1:0]      min_run,
  input  logic [STRIDE_W-1:0]   stride,
  output logic                  busy,
  output logic                  done,
  output logic                  found,
  output logic [COORD_W-1:0]    found_x,
  output logic [COORD_W-1:0]    found_y,
  output logic [COORD_W-1:0]    pix_x,
  output logic [COORD_W-1:0]    pix_y,
  output logic                  req,
`ifdef EDGE_SEARCH_GEN_PIXCOUNT_EN
  output logic [2*COORD_W-1:0]  pix_count,
`endif
  input  logic                  pix,
  input  logic                  ready
);

  state_t               state_q, state_d;
  logic                 pix_q, pix_d;
  logic                 pol_q, pol_d;
  logic [RUN_W-1:0]     min_q, min_d;
  logic [RUN_W-1:0]     run_q, run_d;
  logic [COORD_W-1:0]   run_x_q, run_x_d, run_y_q, run_y_d;
  logic                 found_q, found_d;
  logic [COORD_W-1:0]   fx_q, fx_d, fy_q, fy_d;

  logic                 load, step, line_wrap, out_of_window;
  logic                 hit, start_run, qualify, empty_win;
  logic [RUN_W-1:0]     run_inc, run_next;

  scan_walker #(
    .COORD_W  (COORD_W),
    .STRIDE_W (STRIDE_W)
  ) u_walker (
    .clk           (clk),
    .reset_n       (reset_n),
    .load          (load),
    .step          (step),
    .x0            (search_x0),
    .y0            (search_y0),
    .x1            (search_x1),
    .y1            (search_y1),
    .direction     (direction),
    .stride        (stride),
    .cur_x         (pix_x),
    .cur_y         (pix_y),
    .line_wrap     (line_wrap),
    .out_of_window (out_of_window)
  );

  assign busy    = (state_q == LOAD) || (state_q == REQ) || (state_q == EVAL);
  assign done    = (state_q == DONE);
  assign req     = (state_q == REQ);
  assign found   = found_q;
  assign found_x = fx_q;
  assign found_y = fy_q;

  assign empty_win = (search_x0 > search_x1) || (search_y0 > search_y1);
  assign hit       = (pix_q == pol_q);
  assign run_inc   = (run_q == '1) ? run_q : run_q + RUN_W'(1);
  assign run_next  = hit ? run_inc : '0;
  assign start_run = hit && (run_q == '0);
  assign qualify   = hit && (run_inc == min_q);

  always_comb begin
    state_d = state_q;
    pix_d   = pix_q;
    pol_d   = pol_q;
    min_d   = min_q;
    run_d   = run_q;
    run_x_d = run_x_q;
    run_y_d = run_y_q;
    found_d = found_q;
    fx_d    = fx_q;
    fy_d    = fy_q;
    load    = 1'b0;
    step    = 1'b0;
    unique case (state_q)
      IDLE, DONE: begin
        if (start) begin
          state_d = LOAD;
          found_d = 1'b0;
          fx_d    = '0;
          fy_d    = '0;
        end
      end
      LOAD: begin
        load    = 1'b1;
        pol_d   = polarity;
        min_d   = (min_run == '0) ? RUN_W'(1) : min_run;
        run_d   = '0;
        if (abort || empty_win) state_d = DONE;
        else                    state_d = REQ;
      end
      REQ: begin
        if (abort) begin
          state_d = DONE;
        end else if (ready) begin
          pix_d   = pix;
          state_d = EVAL;
        end
      end
      EVAL: begin
        if (abort) begin
          state_d = DONE;
        end else if (qualify) begin
          found_d = 1'b1;
          fx_d    = start_run ? pix_x : run_x_q;
          fy_d    = start_run ? pix_y : run_y_q;
          state_d = DONE;
        end else if (out_of_window) begin
          state_d = DONE;
        end else begin
          step    = 1'b1;
          // Runs never span scan lines: a wrap discards the partial run.
          run_d   = line_wrap ? '0 : run_next;
          if (start_run) begin
            run_x_d = pix_x;
            run_y_d = pix_y;
          end
          state_d = REQ;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      pix_q   <= 1'b0;
      pol_q   <= 1'b0;
      min_q   <= RUN_W'(1);
      run_q   <= '0;
      run_x_q <= '0;
      run_y_q <= '0;
      found_q <= 1'b0;
      fx_q    <= '0;
      fy_q    <= '0;
    end else begin
      state_q <= state_d;
      pix_q   <= pix_d;
      pol_q   <= pol_d;
      min_q   <= min_d;
      run_q   <= run_d;
      run_x_q <= run_x_d;
      run_y_q <= run_y_d;
      found_q <= found_d;
      fx_q    <= fx_d;
      fy_q    <= fy_d;
    end
  end

`ifdef EDGE_SEARCH_GEN_PIXCOUNT_EN
  logic [2*COORD_W-1:0] cnt_q;

  assign pix_count = cnt_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q <= '0;
    end else if (state_q == LOAD) begin
      cnt_q <= '0;
    end else if (state_q == EVAL) begin
      cnt_q <= cnt_q + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_edge_search_gen.sv
// Directed bench for edge_search_gen: vector table of searches over small
// synthetic images plus abort, latency and asynchronous-reset sequences.
module tb_edge_search_gen;

  logic       clk = 1'b0;
  logic       reset_n, start, abort, polarity, busy, done, found, req, pix, ready;
  logic [9:0] search_x0, search_y0, search_x1, search_y1;
  logic [9:0] found_x, found_y, pix_x, pix_y;
  logic [1:0] direction;
  logic [3:0] min_run, stride;

  logic img [0:15][0:15];
  logic resp_en;
  int   req_count = 0;
  int   odd_count = 0;
  int   total = 0;
  int   bad = 0;

  always #5 clk = ~clk;

  edge_search_gen dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .start     (start),
    .abort     (abort),
    .search_x0 (search_x0),
    .search_y0 (search_y0),
    .search_x1 (search_x1),
    .search_y1 (search_y1),
    .direction (direction),
    .polarity  (polarity),
    .min_run   (min_run),
    .stride    (stride),
    .busy      (busy),
    .done      (done),
    .found     (found),
    .found_x   (found_x),
    .found_y   (found_y),
    .pix_x     (pix_x),
    .pix_y     (pix_y),
    .req       (req),
    .pix       (pix),
    .ready     (ready)
  );

  // Pixel cache: answers each request half a cycle after it appears.
  always @(negedge clk) begin
    if (resp_en && req && !ready) begin
      ready = 1'b1;
      pix   = img[pix_y[3:0]][pix_x[3:0]];
      req_count++;
      if (pix_x[0]) odd_count++;
    end else begin
      ready = 1'b0;
    end
  end

  typedef struct {
    logic [9:0] x0, y0, x1, y1;
    logic [1:0] dir;
    logic       pol;
    logic [3:0] mr, st;
    int         img_sel;
    logic       ef;
    logic [9:0] ex, ey;
    int         ereq;
  } vec_t;

  vec_t vecs[9];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic set_img(input int sel);
    for (int y = 0; y < 16; y++)
      for (int x = 0; x < 16; x++)
        img[y][x] = (sel == 4);
    case (sel)
      0: img[5][5] = 1'b1;
      1: begin
        img[2][3] = 1'b1; img[2][4] = 1'b1; img[1][8] = 1'b1; img[1][9] = 1'b1;
        img[2][0] = 1'b1; img[4][7] = 1'b1; img[4][8] = 1'b1; img[4][9] = 1'b1;
      end
      2: img[5][1] = 1'b1;
      3: img[0][0] = 1'b1;
      5: img[5][4] = 1'b1;
      default: ;
    endcase
  endtask

  task automatic set_mode(input vec_t v);
    search_x0 = v.x0; search_y0 = v.y0; search_x1 = v.x1; search_y1 = v.y1;
    direction = v.dir; polarity = v.pol; min_run = v.mr; stride = v.st;
  endtask

  task automatic pulse_start();
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  task automatic wait_done(output logic ok);
    ok = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      if (done) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  logic ok;
  int   base, obase;

  initial begin
    //           x0  y0  x1  y1  dir  pol mr st img found ex ey reqs
    vecs[0] = '{10'd0, 10'd0, 10'd9, 10'd9, 2'd3, 1'b1, 4'd1, 4'd1, 0, 1'b1, 10'd5, 10'd5, 56};
    vecs[1] = '{10'd0, 10'd0, 10'd9, 10'd9, 2'd3, 1'b1, 4'd3, 4'd1, 1, 1'b1, 10'd7, 10'd4, 50};
    vecs[2] = '{10'd0, 10'd0, 10'd9, 10'd9, 2'd1, 1'b1, 4'd1, 4'd2, 2, 1'b0, 10'd0, 10'd0, 50};
    vecs[3] = '{10'd0, 10'd0, 10'd9, 10'd9, 2'd0, 1'b1, 4'd1, 4'd1, 3, 1'b1, 10'd0, 10'd0, 10};
    vecs[4] = '{10'd0, 10'd0, 10'd9, 10'd9, 2'd2, 1'b1, 4'd1, 4'd1, 3, 1'b1, 10'd0, 10'd0, 10};
    vecs[5] = '{10'd5, 10'd0, 10'd3, 10'd9, 2'd3, 1'b1, 4'd1, 4'd1, 0, 1'b0, 10'd0, 10'd0, 0};
    vecs[6] = '{10'd0, 10'd0, 10'd9, 10'd9, 2'd3, 1'b0, 4'd1, 4'd1, 4, 1'b0, 10'd0, 10'd0, 100};
    vecs[7] = '{10'd2, 10'd3, 10'd6, 10'd7, 2'd3, 1'b1, 4'd0, 4'd0, 5, 1'b1, 10'd4, 10'd5, 13};
    vecs[8] = '{10'd0, 10'd0, 10'd9, 10'd9, 2'd3, 1'b0, 4'd2, 4'd1, 0, 1'b1, 10'd0, 10'd0, 2};

    reset_n = 1'b0; start = 1'b0; abort = 1'b0; resp_en = 1'b1;
    set_mode(vecs[0]);
    set_img(0);
    #12;
    check("reset_outputs", {busy, done, found, req, found_x, found_y, pix_x, pix_y}, '0);
    @(negedge clk);
    reset_n = 1'b1;

    for (int i = 0; i < 9; i++) begin
      set_img(vecs[i].img_sel);
      set_mode(vecs[i]);
      base  = req_count;
      obase = odd_count;
      pulse_start();
      wait_done(ok);
      check($sformatf("v%0d_done", i), ok, 1'b1);
      check($sformatf("v%0d_busy", i), busy, 1'b0);
      check($sformatf("v%0d_found", i), found, vecs[i].ef);
      check($sformatf("v%0d_xy", i), {found_x, found_y}, {vecs[i].ex, vecs[i].ey});
      check($sformatf("v%0d_reqs", i), req_count - base, vecs[i].ereq);
      if (vecs[i].dir == 2'd1) check($sformatf("v%0d_odd_cols", i), odd_count - obase, 0);
    end

    // Abort with ready withheld; also checks start-to-first-req latency.
    resp_en = 1'b0;
    set_img(0);
    set_mode(vecs[0]);
    pulse_start();
    @(negedge clk);
    check("lat_load_no_req", {busy, req}, 2'b10);
    @(negedge clk);
    check("lat_first_req", req, 1'b1);
    repeat (3) @(negedge clk);
    check("req_held_xy", {req, pix_x, pix_y}, {1'b1, 10'd0, 10'd0});
    abort = 1'b1;
    @(posedge clk);
    #1 abort = 1'b0;
    @(negedge clk);
    check("abort_result", {done, found, req, busy}, 4'b1000);
    abort = 1'b1;
    repeat (2) @(negedge clk);
    abort = 1'b0;
    check("abort_in_done_noop", {done, found}, 2'b10);

    // Asynchronous reset mid-search, then a clean rerun with inputs disturbed after LOAD.
    resp_en = 1'b1;
    pulse_start();
    repeat (20) @(negedge clk);
    check("mid_search_busy", busy, 1'b1);
    #2 reset_n = 1'b0;
    #1;
    check("async_reset", {busy, done, found, req, found_x, found_y, pix_x, pix_y}, '0);
    @(negedge clk);
    reset_n = 1'b1;
    base = req_count;
    pulse_start();
    repeat (3) @(negedge clk);
    search_x1 = 10'd2; direction = 2'd2; min_run = 4'd5; polarity = 1'b0;
    wait_done(ok);
    check("rerun_done", ok, 1'b1);
    check("rerun_found", {found, found_x, found_y}, {1'b1, 10'd5, 10'd5});
    check("rerun_reqs", req_count - base, 56);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
